dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Arbitrates the single-port 32-word data memory between two requesters.
  - CPU MEM stage: fixed priority; stalled when it loses.
  - Debug/monitor port: valid/ready handshake; protected by a starvation counter.
- Drives the memory's address, write-enable and write-data pins.
- Routes the 1-cycle-latency read data back to whichever requester issued the read.
- Sits between the pipeline's memory stage and the data memory instance.

Parameters:
- MAX_WAIT, 4: consecutive lost-conflict cycles after which the debug port wins the next conflict (1..15).
- LOCK_MAX, 16: maximum consecutive debug grants under lock; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  5  CPU word address
- cpu_wdata  in  32  CPU store data
- cpu_stall  out  1  CPU request not granted this cycle; hold the request
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- dbg_valid  in  1  debug request
- dbg_we  in  1  debug write (1) / read (0)
- dbg_addr  in  5  debug word address
- dbg_wdata  in  32  debug write data
- dbg_lock  in  1  request back-to-back ownership (optional feature)
- dbg_ready  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  32  debug read data
- mem_we  out  1  memory write enable
- mem_addr  out  5  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid the cycle after the address is presented

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Registered state:
  - wait_cnt: 4 bits, reset 0.
  - owner_q: NONE/CPU/DBG, reset NONE.
  - lock_cnt: reset 0; optional feature only.
- Grant decision is combinational, one grant per cycle:
  - Only cpu_req high -> CPU granted.
  - Only dbg_valid high -> DBG granted.
  - Both high, wait_cnt < MAX_WAIT -> CPU granted.
  - Both high, wait_cnt == MAX_WAIT -> DBG granted.
  - Neither high -> no grant.
- Granted port's we/addr/wdata drive the mem_* pins the same cycle.
- With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Request-side outputs:
  - cpu_stall = cpu_req & ~cpu_grant.
  - dbg_ready = dbg_grant.
  - Both are 0 whenever their request is low.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when dbg_valid is high and DBG is not granted.
  - Clears to 0 on a DBG grant.
  - Holds when dbg_valid is low.
- Debug handshake:
  - dbg_valid, dbg_we, dbg_addr and dbg_wdata are held stable until dbg_ready.
  - Dropping dbg_valid before dbg_ready is a protocol error; behaviour is undefined and checked by assertion.
- Read return:
  - owner_q <= CPU or DBG on a granted read; NONE otherwise (writes, or no grant).
  - cpu_rvalid = (owner_q==CPU); dbg_rvalid = (owner_q==DBG).
  - Each rdata output equals mem_rdata while its rvalid is high, else 0.
  - Read latency is 1 cycle after the grant for both ports.
- No forwarding: read-after-write to the same address in consecutive cycles returns the memory's own semantics.
- Stalled CPU: the CPU re-presents the same request every cycle; each cycle is a fresh arbitration.
- Reset:
  - Reset mid-operation clears owner_q, so an in-flight rvalid is dropped.
  - All outputs read 0 while rst_n is low.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - A DBG grant with dbg_lock=1 enters the locked state.
  - While locked, DBG wins every cycle it requests; cpu_stall=cpu_req.
  - lock_cnt increments per locked grant.
  - Lock releases when dbg_lock drops, dbg_valid drops, or lock_cnt reaches LOCK_MAX.
  - On release, lock_cnt clears and wait_cnt clears.
- Not defined:
  - dbg_lock is ignored and lock_cnt is absent.
  - Arbitration follows the base rules only.

Test Plan:
- CPU read addr 5 alone, mem[5]=32'h1234 -> mem_addr=5 same cycle; cpu_rvalid=1, cpu_rdata=32'h1234 next cycle; cpu_stall=0 throughout.
- cpu_req and dbg_valid held high continuously, MAX_WAIT=4 -> CPU granted 4 cycles, DBG granted on 5th (cpu_stall=1 that cycle only), wait_cnt returns 0, pattern repeats.
- DBG write addr 3 data 32'hDEAD_BEEF alone -> dbg_ready=1 same cycle, mem_we=1; no dbg_rvalid; CPU read addr 3 next cycle returns 32'hDEAD_BEEF.
- Back-to-back CPU read (addr 1) then DBG read (addr 2) -> rvalids alternate: cpu_rvalid in cycle 2, dbg_rvalid in cycle 3, never both high.
- rst_n asserted the cycle after a granted DBG read -> dbg_rvalid stays 0; all outputs 0; after release, first grant behaves normally with wait_cnt=0.
- DMEM_ARB_LOCK_EN, LOCK_MAX=16, dbg_lock=1, both requesting -> DBG holds 16 consecutive grants with cpu_stall=1, then CPU wins the next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (fixed priority)
// and a debug valid/ready port. Optional debug lock ownership: define DMEM_ARB_LOCK_EN.
module dmem_port_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [4:0]  cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        dbg_valid,
   input  logic        dbg_we,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic        dbg_lock,
   output logic        dbg_ready,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        mem_we,
   output logic [4:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_DBG
   } owner_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   owner_t     owner_q, owner_d;
   logic [3:0] wait_cnt, wait_d;
   logic       cpu_grant, dbg_grant;
   logic       lock_active;

`ifdef DMEM_ARB_LOCK_EN
   localparam int LW = $clog2(LOCK_MAX + 1);
   localparam logic [LW-1:0] LOCK_MAX_C = LW'(LOCK_MAX);

   logic          lock_q, lock_d;
   logic [LW-1:0] lock_cnt, lock_cnt_d;

   // Lock ownership lapses the moment the debug side stops asking for it.
   assign lock_active = lock_q & dbg_valid & dbg_lock;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q   <= 1'b0;
         lock_cnt <= '0;
      end else begin
         lock_q   <= lock_d;
         lock_cnt <= lock_cnt_d;
      end
   end
`else
   // dbg_lock and LOCK_MAX only matter when the lock feature is built in.
   logic [32:0] unused_lock;
   assign unused_lock = {dbg_lock, 32'(LOCK_MAX)};
   assign lock_active = 1'b0;
`endif

   // Grants are forced off during reset so every output reads 0 while rst_n is low.
   always_comb begin
      dbg_grant = 1'b0;
      cpu_grant = 1'b0;
      if (rst_n) begin
         dbg_grant = dbg_valid & (~cpu_req | lock_active | (wait_cnt == MAX_WAIT_C));
         cpu_grant = cpu_req & ~dbg_grant;
      end
   end

   assign cpu_stall = cpu_req & ~cpu_grant & rst_n;
   assign dbg_ready = dbg_grant;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 5'd0;
      mem_wdata = 32'd0;
      if (dbg_grant) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else if (cpu_grant) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign cpu_rvalid = (owner_q == OWN_CPU);
   assign dbg_rvalid = (owner_q == OWN_DBG);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : 32'd0;

   // Next-state: read ownership, starvation counter and (optionally) the lock.
   always_comb begin
      owner_d = OWN_NONE;
      wait_d  = wait_cnt;
      if (cpu_grant && !cpu_we) begin
         owner_d = OWN_CPU;
      end else if (dbg_grant && !dbg_we) begin
         owner_d = OWN_DBG;
      end

      if (dbg_grant) begin
         wait_d = 4'd0;
      end else if (dbg_valid && (wait_cnt != MAX_WAIT_C)) begin
         wait_d = wait_cnt + 4'd1;
      end

`ifdef DMEM_ARB_LOCK_EN
      lock_d     = lock_q;
      lock_cnt_d = lock_cnt;
      if (dbg_grant && dbg_lock) begin
         if ((lock_cnt + LW'(1)) == LOCK_MAX_C) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
         end else begin
            lock_d     = 1'b1;
            lock_cnt_d = lock_cnt + LW'(1);
         end
      end else if (lock_q) begin
         lock_d     = 1'b0;
         lock_cnt_d = '0;
         wait_d     = 4'd0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= OWN_NONE;
         wait_cnt <= 4'd0;
      end else begin
         owner_q  <= owner_d;
         wait_cnt <= wait_d;
      end
   end

   // A pending debug request must stay up and unchanged until it is accepted.
   dbg_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
      (dbg_valid && !dbg_ready) |=> (dbg_valid && $stable({dbg_we, dbg_addr, dbg_wdata})));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed stimulus pushes expected grants and
// read returns into queues; a negedge monitor pops and compares whenever the DUT responds.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
   logic [4:0]  cpu_addr;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        dbg_valid, dbg_we, dbg_lock, dbg_ready, dbg_rvalid;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata, dbg_rdata;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        is_dbg;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        stall;
   } grant_t;

   typedef struct {
      logic        is_dbg;
      logic [31:0] data;
   } read_t;

   grant_t gq[$];
   read_t  rq[$];
   logic [31:0] mem [32];

   dmem_port_arbiter #(.MAX_WAIT(4), .LOCK_MAX(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock), .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory, read-first, one cycle read latency.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
         mem[1]    <= 32'h1111_0001;
         mem[2]    <= 32'h2222_0002;
         mem[5]    <= 32'h0000_1234;
         mem_rdata <= 32'd0;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ctl"}, 64'({cpu_stall, cpu_rvalid, dbg_ready, dbg_rvalid, mem_we, mem_addr}), 64'd0);
      checkOutput({tag, "_rdata"}, {cpu_rdata, dbg_rdata}, 64'd0);
      checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   task automatic applyStimulus(input logic rst, input logic creq, input logic cwe, input logic [4:0] caddr,
                                input logic [31:0] cwd, input logic dv, input logic dwe,
                                input logic [4:0] daddr, input logic [31:0] dwd);
      @(posedge clk);
      #1;
      rst_n     = rst;
      cpu_req   = creq;
      cpu_we    = cwe;
      cpu_addr  = caddr;
      cpu_wdata = cwd;
      dbg_valid = dv;
      dbg_we    = dwe;
      dbg_addr  = daddr;
      dbg_wdata = dwd;
   endtask

   task automatic pushGrant(input logic isd, input logic we, input logic [4:0] addr,
                            input logic [31:0] wd, input logic stall);
      grant_t g;
      g.is_dbg = isd; g.we = we; g.addr = addr; g.wdata = wd; g.stall = stall;
      gq.push_back(g);
   endtask

   task automatic pushRead(input logic isd, input logic [31:0] data);
      read_t r;
      r.is_dbg = isd; r.data = data;
      rq.push_back(r);
   endtask

   // Monitor: compares grants and read returns against the queued expectations.
   always @(negedge clk) begin
      grant_t g;
      read_t  r;
      logic   cpu_g;
      cpu_g = rst_n && cpu_req && !cpu_stall;
      checkOutput("single_grant", 64'(cpu_g & dbg_ready), 64'd0);
      if (cpu_g || dbg_ready) begin
         checkOutput("grant_expected", 64'(gq.size() != 0), 64'd1);
         if (gq.size() != 0) begin
            g = gq.pop_front();
            checkOutput("grant_port", 64'(dbg_ready), 64'(g.is_dbg));
            checkOutput("grant_pins", 64'({mem_we, mem_addr, mem_wdata}), 64'({g.we, g.addr, g.wdata}));
            checkOutput("cpu_stall", 64'(cpu_stall), 64'(g.stall));
         end
      end else begin
         checkOutput("idle_pins", 64'({mem_we, mem_addr, mem_wdata}), 64'd0);
      end

      checkOutput("rvalid_exclusive", 64'(cpu_rvalid & dbg_rvalid), 64'd0);
      if (cpu_rvalid || dbg_rvalid) begin
         checkOutput("read_expected", 64'(rq.size() != 0), 64'd1);
         if (rq.size() != 0) begin
            r = rq.pop_front();
            checkOutput("read_port", 64'(dbg_rvalid), 64'(r.is_dbg));
            checkOutput("read_data", 64'(r.is_dbg ? dbg_rdata : cpu_rdata), 64'(r.data));
            checkOutput("read_other_zero", 64'(r.is_dbg ? cpu_rdata : dbg_rdata), 64'd0);
         end
      end else begin
         checkOutput("rdata_idle", {cpu_rdata, dbg_rdata}, 64'd0);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0; dbg_lock = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd9; cpu_wdata = 32'hAAAA_5555;
      dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h5555_AAAA;
      @(negedge clk);
      checkResetOutputs("reset_initial");
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // CPU read alone
      applyStimulus(1, 1, 0, 5'd5, 0, 0, 0, 0, 0);
      pushGrant(0, 0, 5'd5, 32'd0, 0); pushRead(0, 32'h0000_1234);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Debug write, then CPU reads it back
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 5'd3, 32'hDEAD_BEEF);
      pushGrant(1, 1, 5'd3, 32'hDEAD_BEEF, 0);
      applyStimulus(1, 1, 0, 5'd3, 0, 0, 0, 0, 0);
      pushGrant(0, 0, 5'd3, 32'd0, 0); pushRead(0, 32'hDEAD_BEEF);

      // Back-to-back CPU read then debug read
      applyStimulus(1, 1, 0, 5'd1, 0, 0, 0, 0, 0);
      pushGrant(0, 0, 5'd1, 32'd0, 0); pushRead(0, 32'h1111_0001);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 5'd2, 0);
      pushGrant(1, 0, 5'd2, 32'd0, 0); pushRead(1, 32'h2222_0002);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Continuous contention: CPU wins four, debug wins the fifth
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 1, 0, 5'd5, 0, 1, 1, 5'd7, 32'h0000_0077);
         if (i % 5 == 4) pushGrant(1, 1, 5'd7, 32'h0000_0077, 1);
         else begin
            pushGrant(0, 0, 5'd5, 32'd0, 0); pushRead(0, 32'h0000_1234);
         end
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset right after a granted debug read drops its return
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 5'd2, 0);
      pushGrant(1, 0, 5'd2, 32'd0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkResetOutputs("reset_mid_read");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset during contention must clear the starvation count
      applyStimulus(1, 1, 0, 5'd5, 0, 1, 1, 5'd7, 32'h0000_0077);
      pushGrant(0, 0, 5'd5, 32'd0, 0); pushRead(0, 32'h0000_1234);
      applyStimulus(1, 1, 0, 5'd5, 0, 1, 1, 5'd7, 32'h0000_0077);
      pushGrant(0, 0, 5'd5, 32'd0, 0);
      applyStimulus(0, 1, 0, 5'd5, 0, 1, 1, 5'd7, 32'h0000_0077);
      @(negedge clk);
      checkResetOutputs("reset_with_requests");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 1, 0, 5'd5, 0, 1, 1, 5'd7, 32'h0000_0077);
         if (i == 4) pushGrant(1, 1, 5'd7, 32'h0000_0077, 1);
         else begin
            pushGrant(0, 0, 5'd5, 32'd0, 0); pushRead(0, 32'h0000_1234);
         end
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      checkOutput("grant_queue_drained", 64'(gq.size()), 64'd0);
      checkOutput("read_queue_drained", 64'(rq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
